// File: rtl/spi_board_arbiter_if.sv
// Bundle of host-side and board-side SPI signals handled by spi_board_arbiter.
// The slave modport is the arbiter's view; master is the hosts/board side.
interface spi_board_arbiter_if;
  logic [1:0] req_i;
  logic [1:0] gnt_o;
  logic [1:0] sclk_i;
  logic [1:0] copi_i;
  logic [1:0] cs_ni;
  logic [1:0] cipo_o;
  logic       spi_sclk_o;
  logic       spi_copi_o;
  logic       spi_cipo_i;
  logic       flash_cs_no;
  logic       microsd_cs_no;
  logic       busy_o;
  logic [1:0] viol_o;

  modport slave (
    input  req_i, sclk_i, copi_i, cs_ni, spi_cipo_i,
    output gnt_o, cipo_o, spi_sclk_o, spi_copi_o, flash_cs_no, microsd_cs_no,
           busy_o, viol_o
  );

  modport master (
    output req_i, sclk_i, copi_i, cs_ni, spi_cipo_i,
    input  gnt_o, cipo_o, spi_sclk_o, spi_copi_o, flash_cs_no, microsd_cs_no,
           busy_o, viol_o
  );
endinterface

// File: rtl/spi_board_arbiter.sv
// Round-robin owner of the shared board SPI bus (flash + microSD) for two hosts,
// with an idle guard between owners and sticky detection of ungranted chip selects.
module spi_board_arbiter #(
  parameter int unsigned GuardCycles = 4,
  parameter logic        SclkIdle    = 1'b0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  spi_board_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GUARD = 2'd2
  } state_t;

  localparam logic [7:0] GuardLoad = 8'(GuardCycles);

  state_t     state_reg, state_next;
  logic [1:0] gnt_reg, gnt_next;
  logic       owner_reg, owner_next;
  logic       prio_reg, prio_next;
  logic [7:0] guard_reg, guard_next;
  logic       busy_reg;
  logic [1:0] viol_reg;
  logic       winner;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
      gnt_reg   <= 2'b00;
      owner_reg <= 1'b0;
      prio_reg  <= 1'b0;
      guard_reg <= 8'd0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      gnt_reg   <= gnt_next;
      owner_reg <= owner_next;
      prio_reg  <= prio_next;
      guard_reg <= guard_next;
      busy_reg  <= (state_next != IDLE);
    end
  end

  always_comb begin
    state_next = state_reg;
    gnt_next   = gnt_reg;
    owner_next = owner_reg;
    prio_next  = prio_reg;
    guard_next = guard_reg;
    winner     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (|bus.req_i) begin
          // A lone requester wins outright; a tie goes to the priority pointer.
          winner     = (bus.req_i == 2'b11) ? prio_reg : bus.req_i[1];
          owner_next = winner;
          gnt_next   = winner ? 2'b10 : 2'b01;
          prio_next  = ~winner;
          state_next = GRANT;
        end
      end
      GRANT: begin
        if (!bus.req_i[owner_reg]) begin
          gnt_next   = 2'b00;
          guard_next = GuardLoad;
          state_next = GUARD;
        end
      end
      GUARD: begin
        guard_next = guard_reg - 8'd1;
        if (guard_reg == 8'd1) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        gnt_next   = 2'b00;
      end
    endcase
  end

  // Sticky per-host flag: chip select driven low without holding the grant.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_host
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          viol_reg[gi] <= 1'b0;
        end else if (!bus.cs_ni[gi] && !gnt_reg[gi]) begin
          viol_reg[gi] <= 1'b1;
        end
      end

      assign bus.cipo_o[gi] = gnt_reg[gi] ? bus.spi_cipo_i : 1'b1;
    end
  endgenerate

  always_comb begin
    bus.spi_sclk_o    = SclkIdle;
    bus.spi_copi_o    = 1'b1;
    bus.flash_cs_no   = 1'b1;
    bus.microsd_cs_no = 1'b1;
    if (gnt_reg[0]) begin
      bus.spi_sclk_o  = bus.sclk_i[0];
      bus.spi_copi_o  = bus.copi_i[0];
      bus.flash_cs_no = bus.cs_ni[0];
    end else if (gnt_reg[1]) begin
      bus.spi_sclk_o    = bus.sclk_i[1];
      bus.spi_copi_o    = bus.copi_i[1];
      bus.microsd_cs_no = bus.cs_ni[1];
    end
  end

  assign bus.gnt_o  = gnt_reg;
  assign bus.busy_o = busy_reg;
  assign bus.viol_o = viol_reg;

endmodule

// File: doc/spi_board_arbiter.md
# spi_board_arbiter

Shares the on-board SPI bus (common SCLK/COPI/CIPO, separate flash and microSD chip selects) between two SPI host requesters in `sonata_system`. It arbitrates with a req/gnt handshake, routes the granted host's signals to the board pins, and forces both chip selects inactive outside a grant. It enforces an idle guard interval between owners and flags any host that drives its chip select without a grant.

## Interface
Parameters:
- `GuardCycles`, default 4: idle cycles inserted after a release before the next grant; legal range 1..255.
- `SclkIdle`, default 1'b0: SCLK level driven when no host owns the bus.

Ports:
- `clk_i`  in  1  system clock.
- `rst_i`  in  1  asynchronous, active-high reset.
- `req_i`  in  2  bus request; bit 0 = flash host, bit 1 = microSD host.
- `gnt_o`  out  2  bus grant; one-hot or zero.
- `sclk_i`  in  2  per-host SCLK.
- `copi_i`  in  2  per-host COPI.
- `cs_ni`  in  2  per-host chip select, active low.
- `cipo_o`  out  2  per-host CIPO.
- `spi_sclk_o`  out  1  board SCLK.
- `spi_copi_o`  out  1  board COPI.
- `spi_cipo_i`  in  1  board CIPO.
- `flash_cs_no`  out  1  flash chip select, active low.
- `microsd_cs_no`  out  1  microSD chip select, active low.
- `busy_o`  out  1  high in GRANT or GUARD.
- `viol_o`  out  2  sticky: host i drove `cs_ni[i]`=0 while `gnt_o[i]`=0.

## Operation
- FSM states: IDLE, GRANT, GUARD. Reset state is IDLE.
- IDLE: if any `req_i` bit is set, pick a winner, then go to GRANT with `gnt_o` one-hot to the winner.
- Winner selection: the single requester wins. If both request, the winner is the host named by the priority pointer `prio`. Reset value of `prio` is 0 (flash).
- On every grant, `prio` flips to the host that did not win (round-robin).
- GRANT: stay while `req_i[owner]`=1. When it is 0, clear `gnt_o`, load the guard counter with `GuardCycles`, and go to GUARD.
- GUARD: decrement the counter each cycle. At 1, go to IDLE. Counter width is 8 bits.
- A request arriving in GUARD, including re-request by the previous owner, waits and is arbitrated in IDLE.
- Datapath, combinational from `gnt_o`:
  - Flash granted: `spi_sclk_o`=`sclk_i[0]`, `spi_copi_o`=`copi_i[0]`, `flash_cs_no`=`cs_ni[0]`.
  - microSD granted: the same mapping using index 1 and `microsd_cs_no`.
  - No grant: `spi_sclk_o`=`SclkIdle`, `spi_copi_o`=1, both CS=1.
  - The CS of the non-granted device is always 1.
- `cipo_o[i]`=`spi_cipo_i` when `gnt_o[i]`, else 1.
- `viol_o[i]` sets, registered, when `cs_ni[i]`=0 and `gnt_o[i]`=0. It clears only on reset. An ungranted host's CS never reaches the pins.
- Reset mid-transfer: all registers clear asynchronously. Outputs immediately take idle values (no grant), and `viol_o` clears.

## Timing
- Reset values:
  - `gnt_o`=0, `busy_o`=0, `viol_o`=0, `cipo_o`=2'b11.
  - `spi_sclk_o`=`SclkIdle`, `spi_copi_o`=1, both CS=1.
- Grant latency: `req_i` sampled high at edge N in IDLE gives `gnt_o` high after edge N; one cycle.
- Hosts keep CS high until they observe `gnt_o`, and return CS high before dropping `req_i`.
- Release: `req_i` sampled low at edge N gives `gnt_o` low after N. GUARD lasts exactly `GuardCycles` cycles. The next grant is asserted `GuardCycles`+1 edges after N at the earliest.
- `busy_o` is registered with the state. `viol_o` has one cycle latency.
- There is no timeout: an owner may hold the bus indefinitely.

## Test plan
- Reset, then idle for 10 cycles: all outputs hold their reset values, `cipo_o`=2'b11, `viol_o`=0.
- `req_i`=2'b01 at cycle 2: `gnt_o`=01 at cycle 3. `sclk_i[0]`/`copi_i[0]`/`cs_ni[0]` appear on the pins. `microsd_cs_no` stays 1. `cipo_o[0]` follows `spi_cipo_i`.
- `req_i`=2'b11 from reset: flash is granted first. Flash drops req at cycle 10: `gnt_o`=0 at 11 and GUARD for cycles 11–14 (`GuardCycles`=4). microSD is granted at 16. After microSD releases, with both requesting, flash wins.
- `cs_ni[1]`=0 while flash owns the bus: `microsd_cs_no` stays 1, `viol_o`=2'b10 one cycle later, and it stays set until `rst_i`.
- Assert `rst_i` in GRANT mid-burst: `gnt_o`, both CS, and `spi_sclk_o` return to idle values in the same cycle without a clock edge. After release, `prio` is 0.
- `GuardCycles`=1, `SclkIdle`=1: GUARD lasts one cycle and `spi_sclk_o`=1 whenever the bus is unowned.
